// File: rtl/mod_148_timer_bank.sv
// Bank of independent PLCA state-diagram timers. Each channel counts duration x TICK_DIV
// clocks and reports done/not_done levels plus a one-cycle expiry pulse.
module mod_148_timer_bank #(
    parameter int NUM_TIMERS = 2,
    parameter int CNT_W      = 16,
    parameter int TICK_DIV   = 1,
    parameter int DIV_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_TIMERS-1:0]       start,
    input  logic [NUM_TIMERS-1:0]       stop,
    input  logic [NUM_TIMERS*CNT_W-1:0] duration,
    output logic [NUM_TIMERS-1:0]       timer_done,
    output logic [NUM_TIMERS-1:0]       timer_not_done,
    output logic [NUM_TIMERS-1:0]       expire_pulse
);

    // One-hot encoding: each output level is a state flop bit.
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_EXPIRED = 2'b10;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        logic [1:0]       state;
        logic [CNT_W-1:0] remaining;
        logic [DIV_W-1:0] presc;
        logic             pulse;
        logic [CNT_W-1:0] dur;
        logic             tick;

        assign dur  = duration[i*CNT_W +: CNT_W];
        assign tick = (presc == DIV_LAST);

        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (!reset_n) begin
                state     <= ST_IDLE;
                remaining <= '0;
                presc     <= '0;
                pulse     <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (start[i]) begin
                    presc <= '0;
                    if (dur == '0) begin
                        state     <= ST_EXPIRED;
                        remaining <= '0;
                        pulse     <= 1'b1;
                    end else begin
                        state     <= ST_RUN;
                        remaining <= dur;
                    end
                end else if (stop[i]) begin
                    state     <= ST_IDLE;
                    remaining <= '0;
                    presc     <= '0;
                end else if (state == ST_RUN) begin
                    if (tick) begin
                        presc     <= '0;
                        remaining <= remaining - CNT_ONE;
                        // Last tick: leave RUN on this edge so not_done spans exactly D x TICK_DIV cycles.
                        if (remaining == CNT_ONE) begin
                            state <= ST_EXPIRED;
                            pulse <= 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            end
        end

        assign timer_not_done[i] = state[0];
        assign timer_done[i]     = state[1];
        assign expire_pulse[i]   = pulse;
    end

endmodule
